// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_pkg
// Description : Shared constants and state encoding for the configuration loader.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_pkg;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam int         TILE_CFG_W   = 33;
    localparam int         SWITCH_CFG_W = 16;

    localparam logic CLASS_TILE   = 1'b0;
    localparam logic CLASS_SWITCH = 1'b1;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_WRITE  = 3'd4
    } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/cfg_sync_hunter.sv
`default_nettype none
// ============================================================================
// Module      : cfg_sync_hunter
// Description : 8-bit LSB-first shift register that flags the sync byte.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_sync_hunter
    import cfg_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_match
);

    logic [7:0] r_shreg;
    logic [7:0] w_next;

    assign w_next  = {i_bit, r_shreg[7:1]};
    assign o_match = i_shift && (w_next == SYNC_BYTE);

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_shreg <= 8'd0;
        end else if (i_shift) begin
            r_shreg <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module      : config_loader
// Description : Serial framed bitstream to parallel tile/switch-box config writes.
// Revision    : 1.0 - initial release
// ============================================================================
module config_loader
    import cfg_pkg::*;
#(
    parameter int NUM_TILES    = 8,
    parameter int NUM_SWITCHES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sin,
    input  logic                  sin_valid,
    output logic                  cfg_we,
    output logic                  cfg_sel,
    output logic [6:0]            cfg_index,
    output logic [TILE_CFG_W-1:0] cfg_data,
    output logic                  busy,
    output logic                  frame_err,
    output logic [15:0]           frames_done,
    output logic [7:0]            err_count
);

    localparam logic [7:0] c_num_tiles = 8'(NUM_TILES);
    localparam logic [7:0] c_num_sw    = 8'(NUM_SWITCHES);
    localparam logic [5:0] c_tile_last = 6'(TILE_CFG_W - 1);
    localparam logic [5:0] c_sw_last   = 6'(SWITCH_CFG_W - 1);

    cfg_state_t            r_state;
    cfg_state_t            w_state_nxt;
    logic [5:0]            r_bit_cnt;
    logic [7:0]            r_addr;
    logic [TILE_CFG_W-1:0] r_data;
    logic                  r_parity;
    logic                  r_cfg_sel;
    logic [6:0]            r_cfg_index;
    logic [TILE_CFG_W-1:0] r_cfg_data;
    logic                  r_frame_err;
    logic [15:0]           r_frames_done;
    logic [7:0]            r_err_count;

    logic       w_hunt_shift;
    logic       w_match;
    logic       w_sync_hit;
    logic [5:0] w_data_last;
    logic       w_index_ok;
    logic       w_frame_ok;
    logic       w_accept;
    logic       w_reject;

    // The hunter only listens while idle and during the WRITE cycle.
    assign w_hunt_shift = sin_valid && ((r_state == ST_HUNT) || (r_state == ST_WRITE));
    assign w_sync_hit   = w_match && (r_state == ST_HUNT);

    cfg_sync_hunter u_hunter (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_sync_hit),
        .i_shift (w_hunt_shift),
        .i_bit   (sin),
        .o_match (w_match)
    );

    assign w_data_last = (r_addr[7] == CLASS_SWITCH) ? c_sw_last : c_tile_last;
    assign w_index_ok  = (r_addr[7] == CLASS_SWITCH) ? ({1'b0, r_addr[6:0]} < c_num_sw)
                                                     : ({1'b0, r_addr[6:0]} < c_num_tiles);
    assign w_frame_ok  = ((r_parity ^ sin) == 1'b0) && w_index_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_sync_hit) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (sin_valid && (r_bit_cnt == 6'd7)) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (sin_valid && (r_bit_cnt == w_data_last)) w_state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
                if (sin_valid) begin
                    if (w_frame_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_reject    = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end
                end
            end
            ST_WRITE: w_state_nxt = ST_HUNT;
            default:  w_state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt     <= 6'd0;
            r_addr        <= 8'd0;
            r_data        <= '0;
            r_parity      <= 1'b0;
            r_cfg_sel     <= 1'b0;
            r_cfg_index   <= 7'd0;
            r_cfg_data    <= '0;
            r_frame_err   <= 1'b0;
            r_frames_done <= 16'd0;
            r_err_count   <= 8'd0;
        end else begin
            r_frame_err <= w_reject;
            case (r_state)
                ST_HUNT: begin
                    r_bit_cnt <= 6'd0;
                    r_parity  <= 1'b0;
                end
                ST_ADDR: begin
                    if (sin_valid) begin
                        r_addr   <= {sin, r_addr[7:1]};
                        r_parity <= r_parity ^ sin;
                        if (r_bit_cnt == 6'd7) begin
                            r_bit_cnt <= 6'd0;
                            r_data    <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (sin_valid) begin
                        r_parity  <= r_parity ^ sin;
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        // Switch payloads land right-aligned; upper bits stay cleared.
                        if (r_addr[7] == CLASS_SWITCH) begin
                            r_data[SWITCH_CFG_W-1]   <= sin;
                            r_data[SWITCH_CFG_W-2:0] <= r_data[SWITCH_CFG_W-1:1];
                        end else begin
                            r_data <= {sin, r_data[TILE_CFG_W-1:1]};
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_accept) begin
                        r_cfg_sel     <= r_addr[7];
                        r_cfg_index   <= r_addr[6:0];
                        r_cfg_data    <= r_data;
                        r_frames_done <= r_frames_done + 16'd1;
                    end
                    if (w_reject && (r_err_count != 8'hFF)) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cfg_we      = (r_state == ST_WRITE);
    assign busy        = (r_state != ST_HUNT);
    assign cfg_sel     = r_cfg_sel;
    assign cfg_index   = r_cfg_index;
    assign cfg_data    = r_cfg_data;
    assign frame_err   = r_frame_err;
    assign frames_done = r_frames_done;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_loader
// Description : Directed self-checking bench for config_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sin = 1'b0;
    logic        sin_valid = 1'b0;
    logic        cfg_we;
    logic        cfg_sel;
    logic [6:0]  cfg_index;
    logic [32:0] cfg_data;
    logic        busy;
    logic        frame_err;
    logic [15:0] frames_done;
    logic [7:0]  err_count;

    int n_checks   = 0;
    int n_errors   = 0;
    int we_pulses  = 0;
    int err_pulses = 0;
    int we_snap;
    int err_snap;

    always #5 clock = ~clock;

    config_loader #(
        .NUM_TILES    (8),
        .NUM_SWITCHES (4)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_index   (cfg_index),
        .cfg_data    (cfg_data),
        .busy        (busy),
        .frame_err   (frame_err),
        .frames_done (frames_done),
        .err_count   (err_count)
    );

    always @(negedge clock) begin
        if (cfg_we)    we_pulses++;
        if (frame_err) err_pulses++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit gap);
        @(negedge clock);
        sin       = b;
        sin_valid = 1'b1;
        if (gap) begin
            @(negedge clock);
            sin_valid = 1'b0;
            sin       = ~b;
        end
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [32:0] payload,
                              input bit flip, input bit gap);
        logic [7:0] sync_v;
        logic       par;
        int         n;
        sync_v = 8'hA5;
        n      = addr[7] ? 16 : 33;
        par    = (^addr) ^ flip;
        for (int i = 0; i < n; i++) par ^= payload[i];
        for (int i = 0; i < 8; i++) send_bit(sync_v[i], gap);
        for (int i = 0; i < 8; i++) send_bit(addr[i], gap);
        for (int i = 0; i < n; i++) send_bit(payload[i], gap);
        send_bit(par, gap);
    endtask

    // Checks the strobe in the cycle after the parity bit and that it lasts one cycle.
    task automatic expect_result(input string tag, input bit gap, input logic exp_we,
                                 input logic exp_err);
        if (!gap) begin
            @(negedge clock);
            sin_valid = 1'b0;
        end
        check({tag, "_we"}, 64'(cfg_we), 64'(exp_we));
        check({tag, "_err"}, 64'(frame_err), 64'(exp_err));
        @(negedge clock);
        check({tag, "_we_off"}, 64'(cfg_we | frame_err), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_we"}, 64'(cfg_we), 64'd0);
        check({tag, "_sel"}, 64'(cfg_sel), 64'd0);
        check({tag, "_index"}, 64'(cfg_index), 64'd0);
        check({tag, "_data"}, 64'(cfg_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_ferr"}, 64'(frame_err), 64'd0);
        check({tag, "_frames"}, 64'(frames_done), 64'd0);
        check({tag, "_errcnt"}, 64'(err_count), 64'd0);
    endtask

    initial begin
        logic [7:0]  a_v;
        logic [32:0] p_v;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_zero_outputs("reset");

        // Tile write, valid held high
        send_frame(8'h03, 33'h1_2345_6789, 1'b0, 1'b0);
        expect_result("tile", 1'b0, 1'b1, 1'b0);
        check("tile_sel", 64'(cfg_sel), 64'd0);
        check("tile_index", 64'(cfg_index), 64'd3);
        check("tile_data", 64'(cfg_data), 64'h1_2345_6789);
        check("tile_frames", 64'(frames_done), 64'd1);
        check("tile_busy", 64'(busy), 64'd0);

        // Switch write, valid toggled every other cycle
        send_frame(8'h81, 33'h0_0000_BEEF, 1'b0, 1'b1);
        expect_result("sw", 1'b1, 1'b1, 1'b0);
        check("sw_sel", 64'(cfg_sel), 64'd1);
        check("sw_index", 64'(cfg_index), 64'd1);
        check("sw_data", 64'(cfg_data), 64'h0_0000_BEEF);
        check("sw_frames", 64'(frames_done), 64'd2);

        // Parity error, then a good frame
        send_frame(8'h03, 33'h0_1111_2222, 1'b1, 1'b0);
        expect_result("par", 1'b0, 1'b0, 1'b1);
        check("par_errcnt", 64'(err_count), 64'd1);
        check("par_data_hold", 64'(cfg_data), 64'h0_0000_BEEF);
        check("par_frames", 64'(frames_done), 64'd2);
        send_frame(8'h05, 33'h1_FFFF_0000, 1'b0, 1'b0);
        expect_result("after_par", 1'b0, 1'b1, 1'b0);
        check("after_par_data", 64'(cfg_data), 64'h1_FFFF_0000);
        check("after_par_index", 64'(cfg_index), 64'd5);

        // Index range boundaries
        send_frame(8'h08, 33'h0_0000_0001, 1'b0, 1'b0);
        expect_result("tile_oor", 1'b0, 1'b0, 1'b1);
        check("tile_oor_errcnt", 64'(err_count), 64'd2);
        send_frame(8'h84, 33'h0_0000_1234, 1'b0, 1'b0);
        expect_result("sw_oor", 1'b0, 1'b0, 1'b1);
        check("sw_oor_errcnt", 64'(err_count), 64'd3);
        send_frame(8'h07, 33'h0_DEAD_BEEF, 1'b0, 1'b0);
        expect_result("tile_max", 1'b0, 1'b1, 1'b0);
        check("tile_max_data", 64'(cfg_data), 64'h0_DEAD_BEEF);
        send_frame(8'h83, 33'h0_0000_5A5A, 1'b0, 1'b0);
        expect_result("sw_max", 1'b0, 1'b1, 1'b0);
        check("sw_max_data", 64'(cfg_data), 64'h0_0000_5A5A);
        check("sw_max_frames", 64'(frames_done), 64'd5);

        // Reset after 20 payload bits aborts silently
        we_snap  = we_pulses;
        err_snap = err_pulses;
        a_v = 8'h01;
        p_v = 33'h0_000F_FFFF;
        for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(a_v[i], 1'b0);
        for (int i = 0; i < 20; i++) send_bit(p_v[i], 1'b0);
        @(negedge clock);
        sin_valid = 1'b0;
        check("abort_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_zero_outputs("abort_reset");
        repeat (3) @(negedge clock);
        check("abort_no_we", 64'(we_pulses - we_snap), 64'd0);
        check("abort_no_err", 64'(err_pulses - err_snap), 64'd0);
        send_frame(8'h02, 33'h1_0000_0001, 1'b0, 1'b0);
        expect_result("post_abort", 1'b0, 1'b1, 1'b0);
        check("post_abort_we_count", 64'(we_pulses - we_snap), 64'd1);
        check("post_abort_data", 64'(cfg_data), 64'h1_0000_0001);
        check("post_abort_frames", 64'(frames_done), 64'd1);
        check("post_abort_errcnt", 64'(err_count), 64'd0);

        // Back-to-back frames with sync pattern in payload
        we_snap = we_pulses;
        send_frame(8'h81, 33'h0_0000_A5A5, 1'b0, 1'b0);
        send_frame(8'h06, 33'h0_A5A5_A5A5, 1'b0, 1'b0);
        expect_result("b2b", 1'b0, 1'b1, 1'b0);
        check("b2b_we_count", 64'(we_pulses - we_snap), 64'd2);
        check("b2b_data", 64'(cfg_data), 64'h0_A5A5_A5A5);
        check("b2b_index", 64'(cfg_index), 64'd6);
        check("b2b_frames", 64'(frames_done), 64'd3);
        check("b2b_errcnt", 64'(err_count), 64'd0);

        // Error counter saturation
        err_snap = err_pulses;
        for (int k = 0; k < 255; k++) begin
            send_frame(8'h80, 33'h0, 1'b1, 1'b0);
            @(negedge clock);
            sin_valid = 1'b0;
            repeat (2) @(negedge clock);
        end
        check("sat_255", 64'(err_count), 64'd255);
        send_frame(8'h80, 33'h0, 1'b1, 1'b0);
        expect_result("sat_256", 1'b0, 1'b0, 1'b1);
        check("sat_hold", 64'(err_count), 64'd255);
        check("sat_pulses", 64'(err_pulses - err_snap), 64'd256);
        check("sat_frames", 64'(frames_done), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/config_loader.md
# config_loader

Serial configuration loader for the fabric. It receives a framed, LSB-first bitstream on a single data bit with a valid qualifier, validates each frame, and emits one parallel write per frame. Each write targets either a logic tile's 33-bit configuration memory (32 LUT bits plus the register-select bit) or a 4x4 switch box's 16-bit crosspoint configuration. It is the writer side of the tile and switch-box configuration storage and sits between the external programming pin and the fabric array.

## Interface
- NUM_TILES, 8, number of addressable logic tiles (1..128)
- NUM_SWITCHES, 4, number of addressable switch boxes (1..128)
- clock  in  1  single system clock; all logic on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clock
- sin  in  1  serial bitstream bit
- sin_valid  in  1  sin is consumed on any cycle where this is high; no backpressure
- cfg_we  out  1  one-cycle write strobe
- cfg_sel  out  1  0 = logic tile, 1 = switch box
- cfg_index  out  7  target index within the selected class
- cfg_data  out  33  configuration word; for switch boxes [15:0] is valid and [32:16] is 0
- busy  out  1  high in any state other than HUNT
- frame_err  out  1  one-cycle pulse when a frame is rejected
- frames_done  out  16  count of frames written; wraps
- err_count  out  8  count of rejected frames; saturates at 255

## Operation
- Frame format, with all fields LSB-first:
  - 8-bit sync 0xA5.
  - 8-bit address: bit7 is the class (0 = tile, 1 = switch), bits6:0 are the index.
  - Payload: 33 bits for a tile, 16 bits for a switch.
  - One parity bit.
- Even parity rule: the XOR of all address bits, all payload bits, and the parity bit must equal 0.
- States: HUNT, ADDR, DATA, PARITY, WRITE.
- HUNT:
  - Each accepted bit shifts into the MSB of an 8-bit hunt register.
  - When the register equals 0xA5 after a shift, go to ADDR and clear the hunt register.
- ADDR: collect 8 bits, then go to DATA. The payload length is latched from address bit7.
- DATA: collect 33 or 16 bits into the data shift register, then go to PARITY.
- PARITY: on the accepted bit, evaluate the frame.
  - Accept if parity is correct and the index is below NUM_TILES (class 0) or below NUM_SWITCHES (class 1). Go to WRITE.
  - Otherwise pulse frame_err, increment err_count (saturating), and return to HUNT.
- WRITE:
  - Assert cfg_we for exactly one cycle and increment frames_done.
  - Return to HUNT unconditionally.
  - If sin_valid is high during WRITE, that bit is fed to the hunt register.
- cfg_sel, cfg_index and cfg_data are registered. They update only on entry to WRITE and hold their value until the next write.
- Bit counters and the running parity advance only on cycles with sin_valid high. Idle gaps of any length inside a frame are legal.

## Timing
- Reset sets state to HUNT and clears the hunt register, the counters and running parity. Every output resets to 0: cfg_we, cfg_sel, cfg_index, cfg_data, busy, frame_err, frames_done, err_count.
- Reset asserted mid-frame aborts the frame silently: no cfg_we, no frame_err, no counter change.
- Latency: cfg_we is high in the cycle after the posedge that accepts the parity bit. With sin_valid held high, that is 8+8+N+1 accepted bits after the first sync bit (N = 33 or 16), plus one cycle.
- frame_err pulses in the same cycle position that cfg_we would have occupied.
- Sync patterns embedded in payload are not detected. Hunting resumes only after WRITE or a rejection.
- frames_done wraps 0xFFFF -> 0x0000. err_count holds at 0xFF.
- busy is high from the cycle after sync detection through the WRITE cycle inclusive.

## Structure
- Shared package cfg_pkg holds:
  - SYNC_BYTE = 8'hA5, TILE_CFG_W = 33, SWITCH_CFG_W = 16.
  - CLASS_TILE and CLASS_SWITCH constants.
  - The state enum.
- Tile and switch-box configuration widths are taken from the package so that the loader and the fabric agree on them.
- One sub-module is natural: cfg_sync_hunter, the 8-bit shift register and comparator, with a clear input. Everything else lives in config_loader.

## Test plan
- Tile write: sync 0xA5, address 0x03, payload 33'h1_2345_6789, correct parity, sin_valid held high -> one cfg_we pulse with cfg_sel=0, cfg_index=3, cfg_data=33'h1_2345_6789; frames_done=1.
- Switch write with sin_valid toggled 50%: address 0x81, payload 16'hBEEF -> cfg_sel=1, cfg_index=1, cfg_data=33'h0_0000_BEEF; timing stretches but the data is exact.
- Flipped parity bit on a tile frame -> no cfg_we; frame_err pulses once; err_count=1; cfg_data keeps its prior value. A following valid frame writes normally.
- Out-of-range index: address 0x08 with NUM_TILES=8, or address 0x84 with NUM_SWITCHES=4 -> frame rejected; err_count increments each time.
- Reset asserted after 20 payload bits, then a full valid frame -> no write or error from the aborted frame; exactly one write from the new frame; all outputs were 0 in the cycle after reset.
- Back-to-back frames with no gap, and payload containing 0xA5 -> two writes, no false sync; 256 bad frames -> err_count saturates at 255.
